ifetch_buf: RTL and testbench

IFETCH_BUF -- requirements
Module: ifetch_buf

---
 rtl/ifetch_buf.sv | 203 ++++++++++++++++++++
 tb/tb_ifetch_buf.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/ifetch_buf.sv
// ifetch_buf -- instruction fetch unit with a small prefetch queue.
//
// Issues sequential reads to a one-cycle-latency instruction memory and parks
// the returned words, tagged with their address, in a DEPTH-entry FIFO that
// feeds the decode stage through a valid/ready handshake. A redirect from the
// execute stage flushes the queue and restarts fetching at the target address.
//
// Parameters:
//   ADDR_W   instruction-address width
//   INSTR_W  instruction word width
//   DEPTH    queue entries (power of two, >= 2)
//   RESET_PC first fetch address after reset
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   iBr_taken, iBr_dir  redirect request and target
//   oImemReq, oImemAddr instruction-memory read strobe and address
//   iImemData           read data, valid one cycle after oImemReq
//   oValid, iReady      head handshake towards decode
//   oInstr, oPc         head instruction and its address (zero when empty)
//   oNew_pc             oPc + 1 (zero when empty)
//   oCount              queue occupancy
//   oFetchCnt           accepted handshakes   (IFETCH_BUF_PERF_EN only)
//   oStallCnt           cycles without a head (IFETCH_BUF_PERF_EN only)
//
// Build option: define IFETCH_BUF_PERF_EN to add the two performance counters.

module ifetch_buf #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     iBr_taken,
    input  logic [ADDR_W-1:0]        iBr_dir,
    output logic                     oImemReq,
    output logic [ADDR_W-1:0]        oImemAddr,
    input  logic [INSTR_W-1:0]       iImemData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic [INSTR_W-1:0]       oInstr,
    output logic [ADDR_W-1:0]        oPc,
    output logic [ADDR_W-1:0]        oNew_pc,
    output logic [$clog2(DEPTH):0]   oCount
`ifdef IFETCH_BUF_PERF_EN
    ,
    output logic [31:0]              oFetchCnt,
    output logic [31:0]              oStallCnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_RST    = ADDR_W'(RESET_PC);

    // Fetch pointer and the single outstanding request (memory latency is one cycle).
    logic [ADDR_W-1:0] fpc_q, fpc_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;

    // Queue bookkeeping.
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Queue storage; contents are only observed through the count, so no reset.
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0]  pc_mem    [DEPTH];

    logic              head_valid;
    logic              req;
    logic              push;
    logic              pop;
    logic [OCC_W-1:0]  occupancy;
    logic [ADDR_W-1:0] head_pc;

    // ------------------------------------------------------------------
    // Handshake / credit decode
    // ------------------------------------------------------------------
    always_comb begin
        head_valid = (count_q != '0) && !reset;
        occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        // Queued plus in-flight entries never exceed DEPTH, so a response
        // always finds a free slot even if decode stalls.
        req        = !reset && !iBr_taken && (occupancy < DEPTH_OCC);
        // Responses arriving in a redirect cycle belong to the old stream.
        push       = inflight_q && !reset && !iBr_taken;
        pop        = head_valid && iReady && !iBr_taken;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = req;
        inflight_pc_d = fpc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (iBr_taken) begin
            fpc_d    = iBr_dir;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (req) begin
                fpc_d = fpc_q + ADDR_ONE;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            fpc_q         <= PC_RST;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= iImemData;
            pc_mem[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        head_pc   = pc_mem[rd_ptr_q];
        oImemReq  = req;
        oImemAddr = fpc_q;
        oValid    = head_valid;
        oCount    = count_q;
        oInstr    = '0;
        oPc       = '0;
        oNew_pc   = '0;
        if (head_valid) begin
            oInstr  = instr_mem[rd_ptr_q];
            oPc     = head_pc;
            oNew_pc = head_pc + ADDR_ONE;
        end
    end

`ifdef IFETCH_BUF_PERF_EN
    // Counters track the consumer side only; redirects leave them alone.
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (pop) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (!head_valid) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign oFetchCnt = fetch_cnt_q;
    assign oStallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// Self-checking bench for ifetch_buf: directed phases (reset release with an
// address wrap, decode stall, redirect, mid-stream reset) followed by a long
// randomized run, all compared cycle by cycle against a queue-based model.

module tb_ifetch_buf;

    localparam int unsigned AW    = 10;
    localparam int unsigned IW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned RPC   = 1022;
    localparam int unsigned AMOD  = 1 << AW;
    localparam int          NCYC  = 3000;

    logic          clk = 1'b0;
    logic          reset;
    logic          iBr_taken;
    logic [AW-1:0] iBr_dir;
    logic          oImemReq;
    logic [AW-1:0] oImemAddr;
    logic [IW-1:0] iImemData;
    logic          oValid;
    logic          iReady;
    logic [IW-1:0] oInstr;
    logic [AW-1:0] oPc;
    logic [AW-1:0] oNew_pc;
    logic [2:0]    oCount;
`ifdef IFETCH_BUF_PERF_EN
    logic [31:0]   oFetchCnt;
    logic [31:0]   oStallCnt;
`endif

    ifetch_buf #(
        .ADDR_W  (AW),
        .INSTR_W (IW),
        .DEPTH   (DEPTH),
        .RESET_PC(RPC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .iBr_taken(iBr_taken),
        .iBr_dir  (iBr_dir),
        .oImemReq (oImemReq),
        .oImemAddr(oImemAddr),
        .iImemData(iImemData),
        .oValid   (oValid),
        .iReady   (iReady),
        .oInstr   (oInstr),
        .oPc      (oPc),
        .oNew_pc  (oNew_pc),
        .oCount   (oCount)
`ifdef IFETCH_BUF_PERF_EN
        ,
        .oFetchCnt(oFetchCnt),
        .oStallCnt(oStallCnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Memory contents: injective in the address so a wrong tag or word shows up.
    function automatic logic [IW-1:0] mem_f(input int unsigned a);
        return IW'((a * 37 + 5) ^ 32'h0000_B400);
    endfunction

    // Reference model: program-order list of queued addresses, one pending
    // request, fetch pointer, perf counts.
    int unsigned m_q[$];
    int unsigned m_fpc;
    bit          m_pend;
    int unsigned m_pend_pc;
    int unsigned m_fetch;
    int unsigned m_stall;

    function automatic bit model_req();
        return !reset && !iBr_taken && ((m_q.size() + int'(m_pend)) < DEPTH);
    endfunction

    task automatic model_step();
        bit req_now;
        req_now = model_req();
        if (reset) begin
            m_fpc = RPC;
            m_q.delete();
            m_pend  = 0;
            m_fetch = 0;
            m_stall = 0;
        end else begin
            if (m_q.size() == 0) m_stall++;
            if (iBr_taken) begin
                m_fpc = iBr_dir;
                m_q.delete();
                m_pend = 0;
            end else begin
                if (m_q.size() > 0 && iReady) begin
                    void'(m_q.pop_front());
                    m_fetch++;
                end
                if (m_pend) m_q.push_back(m_pend_pc);
                m_pend    = req_now;
                m_pend_pc = m_fpc;
                if (req_now) m_fpc = (m_fpc + 1) % AMOD;
            end
        end
    endtask

    task automatic check_outputs();
        bit          exp_req;
        bit          exp_valid;
        int unsigned head;
        exp_req   = model_req();
        exp_valid = !reset && (m_q.size() > 0);
        head      = exp_valid ? m_q[0] : 0;
        check_eq("imem_req", 32'(oImemReq), 32'(exp_req));
        if (exp_req) check_eq("imem_addr", 32'(oImemAddr), m_fpc);
        check_eq("valid", 32'(oValid), 32'(exp_valid));
        check_eq("instr", 32'(oInstr), exp_valid ? 32'(mem_f(head)) : 32'd0);
        check_eq("pc", 32'(oPc), head);
        check_eq("new_pc", 32'(oNew_pc), exp_valid ? (head + 1) % AMOD : 32'd0);
        check_eq("count", 32'(oCount), m_q.size());
`ifdef IFETCH_BUF_PERF_EN
        check_eq("fetch_cnt", oFetchCnt, m_fetch);
        check_eq("stall_cnt", oStallCnt, m_stall);
`endif
    endtask

    bit            mem_rsp_v    = 0;
    logic [AW-1:0] mem_rsp_addr = '0;

    initial begin
        reset     = 1'b1;
        iBr_taken = 1'b0;
        iBr_dir   = '0;
        iReady    = 1'b0;
        iImemData = '0;
        @(posedge clk);
        model_step();
        #1;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            reset     = 1'b0;
            iBr_taken = 1'b0;
            iBr_dir   = AW'($urandom);
            iReady    = 1'b1;
            if (cyc < 30) begin
                // reset release with RESET_PC near the top: 1022, 1023, 0, 1, ...
            end else if (cyc < 42) begin
                iReady = 1'b0;                      // queue saturates, head held
            end else if (cyc == 42) begin
                iBr_taken = 1'b1;
                iBr_dir   = AW'(48);
            end else if (cyc == 50 || cyc == 51) begin
                iReady = 1'b0;                      // build up occupancy
            end else if (cyc == 52) begin
                reset = 1'b1;                       // mid-stream reset
            end else if (cyc > 60) begin
                reset     = ($urandom % 60) == 0;
                iBr_taken = ($urandom % 10) == 0;
                if (($urandom % 4) == 0) iBr_dir = AW'(AMOD - 1 - ($urandom % 3));
                if (((cyc / 40) % 3) == 2) iReady = ($urandom % 6) == 0;
                else                       iReady = ($urandom % 4) != 0;
            end
            iImemData = mem_rsp_v ? mem_f(mem_rsp_addr) : IW'($urandom);
            @(negedge clk);
            check_outputs();
            mem_rsp_v    = oImemReq;
            mem_rsp_addr = oImemAddr;
            @(posedge clk);
            model_step();
            #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
